// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: FSM state encoding, master IDs and bus widths.
package mem_bus_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2
    } arb_state_e;

    typedef enum logic {
        MST_DATA  = 1'b0,
        MST_FETCH = 1'b1
    } mst_id_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/mem_bus_arbiter_arb_timeout_cnt.sv
// Response wait counter: counts cycles spent waiting for the slave and flags expiry
// on the TIMEOUT_CYCLES-th waiting cycle. Only instantiated when ARB_TIMEOUT_EN is defined.
module arb_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic wait_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of earlier waiting cycles, so it is 0 on entry.
    always_comb begin
        cnt_d = wait_i ? cnt_q + CNT_W'(1) : '0;
    end

    assign expired_o = wait_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter (M0 data, M1 fetch) in front of one single-port memory slave.
// Define ARB_TIMEOUT_EN to build in the response timeout (error response after TIMEOUT_CYCLES).
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic              m0_we_i,
    input  logic [BE_W-1:0]   m0_be_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_err_o,
    input  logic              m1_req_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic              m1_we_i,
    input  logic [BE_W-1:0]   m1_be_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_err_o,
    output logic              s_req_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic              s_we_o,
    output logic [BE_W-1:0]   s_be_o,
    output logic [DATA_W-1:0] s_wdata_o,
    input  logic              s_ready_i,
    input  logic              s_rvalid_i,
    input  logic [DATA_W-1:0] s_rdata_i,
    output logic              hold_o
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e          state_q, state_d;
    mst_id_e             owner_q, owner_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

    mst_id_e  arb_sel;
    bus_req_t mst0_req, mst1_req, cur_req;
    logic     any_req, starved, bus_req, gnt, rsp_valid, rsp_err, timeout_exp;

    assign mst0_req = '{addr: m0_addr_i, we: m0_we_i, be: m0_be_i, wdata: m0_wdata_i};
    assign mst1_req = '{addr: m1_addr_i, we: m1_we_i, be: m1_be_i, wdata: m1_wdata_i};
    assign any_req  = m0_req_i | m1_req_i;
    assign starved  = (starve_cnt_q == STARVE_W'(STARVE_LIMIT));

`ifdef ARB_TIMEOUT_EN
    arb_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .wait_i   (state_q == ST_WAIT_RSP),
        .expired_o(timeout_exp)
    );
`else
    // The timeout length only matters when the counter is built in.
    assign timeout_exp = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    // Selection is live only in IDLE; afterwards the owner stays locked until its response.
    always_comb begin
        arb_sel = owner_q;
        if (state_q == ST_IDLE) begin
            arb_sel = (m1_req_i && (!m0_req_i || starved)) ? MST_FETCH : MST_DATA;
        end
    end

    assign cur_req = (arb_sel == MST_FETCH) ? mst1_req : mst0_req;

    // NOTE: every variable driven in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    owner_d = arb_sel;
                    state_d = s_ready_i ? ST_WAIT_RSP : ST_REQ;
                end
            end
            ST_REQ:      if (s_ready_i) state_d = ST_WAIT_RSP;
            ST_WAIT_RSP: if (s_rvalid_i || timeout_exp) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_req   = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        unique case (state_q)
            ST_IDLE:     bus_req = any_req;
            ST_REQ:      bus_req = 1'b1;
            ST_WAIT_RSP: begin
                rsp_valid = s_rvalid_i | timeout_exp;
                rsp_err   = timeout_exp & ~s_rvalid_i;
            end
            default: ;
        endcase
    end

    assign gnt = bus_req & s_ready_i;

    // Counts contended M0 grants; any cycle without an M1 request restarts the count.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!m1_req_i || (gnt && arb_sel == MST_FETCH)) begin
            starve_cnt_d = '0;
        end else if (gnt && !starved) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end
    end

    // Every port is forced to 0 while rst is low, including the combinational paths.
    always_comb begin
        s_req_o     = 1'b0;
        s_addr_o    = '0;
        s_we_o      = 1'b0;
        s_be_o      = '0;
        s_wdata_o   = '0;
        m0_gnt_o    = 1'b0;
        m1_gnt_o    = 1'b0;
        m0_rvalid_o = 1'b0;
        m1_rvalid_o = 1'b0;
        m0_rdata_o  = '0;
        m1_rdata_o  = '0;
        m0_err_o    = 1'b0;
        m1_err_o    = 1'b0;
        hold_o      = 1'b0;
        if (rst) begin
            s_req_o     = bus_req;
            s_addr_o    = cur_req.addr;
            s_we_o      = cur_req.we;
            s_be_o      = cur_req.be;
            s_wdata_o   = cur_req.wdata;
            m0_gnt_o    = gnt & (arb_sel == MST_DATA);
            m1_gnt_o    = gnt & (arb_sel == MST_FETCH);
            m0_rvalid_o = rsp_valid & (owner_q == MST_DATA);
            m1_rvalid_o = rsp_valid & (owner_q == MST_FETCH);
            m0_rdata_o  = (m0_rvalid_o && s_rvalid_i) ? s_rdata_i : '0;
            m1_rdata_o  = (m1_rvalid_o && s_rvalid_i) ? s_rdata_i : '0;
            m0_err_o    = rsp_err & (owner_q == MST_DATA);
            m1_err_o    = rsp_err & (owner_q == MST_FETCH);
            hold_o      = (any_req & ~rsp_valid) | ((state_q != ST_IDLE) & ~s_rvalid_i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= MST_DATA;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a randomized phase,
// all checked against a transaction-level model of the arbitration rules.
module tb_mem_bus_arbiter;

    localparam int LIMIT = 4;
    localparam int TMO   = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        m_req[2];
    logic [31:0] m_addr[2];
    logic        m_we[2];
    logic [3:0]  m_be[2];
    logic [31:0] m_wdata[2];
    logic        gnt_w[2];
    logic        rv_w[2];
    logic        err_w[2];
    logic [31:0] rdata_w[2];
    logic        s_req_o, s_we_o, s_ready_i, s_rvalid_i, hold_o;
    logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
    logic [3:0]  s_be_o;

    mem_bus_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m_req[0]), .m0_addr_i(m_addr[0]), .m0_we_i(m_we[0]), .m0_be_i(m_be[0]),
        .m0_wdata_i(m_wdata[0]), .m0_gnt_o(gnt_w[0]), .m0_rvalid_o(rv_w[0]),
        .m0_rdata_o(rdata_w[0]), .m0_err_o(err_w[0]),
        .m1_req_i(m_req[1]), .m1_addr_i(m_addr[1]), .m1_we_i(m_we[1]), .m1_be_i(m_be[1]),
        .m1_wdata_i(m_wdata[1]), .m1_gnt_o(gnt_w[1]), .m1_rvalid_o(rv_w[1]),
        .m1_rdata_o(rdata_w[1]), .m1_err_o(err_w[1]),
        .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
        .s_wdata_o(s_wdata_o), .s_ready_i(s_ready_i), .s_rvalid_i(s_rvalid_i),
        .s_rdata_i(s_rdata_i), .hold_o(hold_o)
    );

    // Reference model state (transaction level)
    int          busy_owner, locked, starve, wait_cnt, last_gnt, cyc;
    bit          waiting[2];
    bit          pend;
    int          pend_dly;
    logic [31:0] pend_data;
    logic [31:0] exp_rd[2];
    bit          exp_we[2];
    logic [31:0] slave_mem[256];
    logic [31:0] ref_mem[256];
    logic [31:0] last_rdata[2];
    int          rv_cyc[2];
    int          grant_log[$];
    int          grant_cyc[$];
    int          want_pct[2];
    int          ready_pct, fixed_lat;
    bit          spurious, no_rsp;
    int          total, passed;
    int          t3_exp[6] = '{0, 0, 0, 0, 1, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    task automatic issue(input int x, input logic [31:0] addr, input logic we,
                         input logic [3:0] be, input logic [31:0] wdata);
        m_req[x] = 1'b1; m_addr[x] = addr; m_we[x] = we; m_be[x] = be; m_wdata[x] = wdata;
    endtask

    task automatic new_txn(input int x);
        logic [7:0] w;
        w = 8'($urandom_range(0, 255));
        issue(x, {22'd0, w, 2'b00}, (x == 0) ? 1'($urandom_range(0, 1)) : 1'b0,
              (x == 0) ? 4'($urandom_range(1, 15)) : 4'hF, $urandom);
    endtask

    task automatic model_reset();
        busy_owner = -1; locked = -1; starve = 0; wait_cnt = 0; last_gnt = -1;
        pend = 1'b0; pend_dly = 0; waiting[0] = 1'b0; waiting[1] = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_sreq"}, 32'(s_req_o), 32'd0);
        check({tag, "_saddr"}, s_addr_o, 32'd0);
        check({tag, "_gnt0"}, 32'(gnt_w[0]), 32'd0);
        check({tag, "_gnt1"}, 32'(gnt_w[1]), 32'd0);
        check({tag, "_rv0"}, 32'(rv_w[0]), 32'd0);
        check({tag, "_rv1"}, 32'(rv_w[1]), 32'd0);
        check({tag, "_hold"}, 32'(hold_o), 32'd0);
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, update model, return at posedge+1.
    task automatic cycle();
        int sel;
        bit outst, e_sreq, e_gnt, e_rv, e_err, e_hold, rvx;
        logic [31:0] e_rdata;
        int idx;
        if (last_gnt >= 0) begin m_req[last_gnt] = 1'b0; last_gnt = -1; end
        for (int x = 0; x < 2; x++)
            if (!m_req[x] && !waiting[x] && $urandom_range(1, 100) <= want_pct[x]) new_txn(x);
        s_ready_i  = ($urandom_range(1, 100) <= ready_pct);
        s_rvalid_i = (pend && pend_dly == 0 && !no_rsp) || spurious;
        s_rdata_i  = (pend && pend_dly == 0) ? pend_data : $urandom;
        @(negedge clk);
        sel = -1; e_sreq = 1'b0; e_rv = 1'b0; e_err = 1'b0;
        outst = (busy_owner >= 0);
        if (outst) begin
            e_rv = s_rvalid_i;
`ifdef ARB_TIMEOUT_EN
            e_err = !s_rvalid_i && (wait_cnt == TMO - 1);
            e_rv  = e_rv || e_err;
`endif
        end else if (locked >= 0) begin
            sel = locked; e_sreq = 1'b1;
        end else if (m_req[0] || m_req[1]) begin
            sel = (m_req[1] && (!m_req[0] || starve == LIMIT)) ? 1 : 0;
            e_sreq = 1'b1;
        end
        e_gnt  = e_sreq && s_ready_i;
        e_hold = ((m_req[0] || m_req[1]) && !e_rv) || ((outst || locked >= 0) && !s_rvalid_i);

        check("s_req", 32'(s_req_o), 32'(e_sreq));
        if (e_sreq) begin
            check("s_addr", s_addr_o, m_addr[sel]);
            check("s_we", 32'(s_we_o), 32'(m_we[sel]));
            check("s_be", 32'(s_be_o), 32'(m_be[sel]));
            if (m_we[sel]) check("s_wdata", s_wdata_o, m_wdata[sel]);
        end
        check("gnt0", 32'(gnt_w[0]), 32'(e_gnt && sel == 0));
        check("gnt1", 32'(gnt_w[1]), 32'(e_gnt && sel == 1));
        check("hold", 32'(hold_o), 32'(e_hold));
        for (int x = 0; x < 2; x++) begin
            rvx = e_rv && (busy_owner == x);
            e_rdata = (!rvx || e_err) ? 32'd0 : (exp_we[x] ? s_rdata_i : exp_rd[x]);
            check(x == 0 ? "rvalid0" : "rvalid1", 32'(rv_w[x]), 32'(rvx));
            check(x == 0 ? "rdata0" : "rdata1", rdata_w[x], e_rdata);
            check(x == 0 ? "err0" : "err1", 32'(err_w[x]), 32'(rvx && e_err));
            if (rvx) begin last_rdata[x] = rdata_w[x]; rv_cyc[x] = cyc; end
        end

        if (e_rv) begin
            waiting[busy_owner] = 1'b0; busy_owner = -1;
        end else if (outst) begin
            wait_cnt++;
        end
        if (pend) begin
            if (pend_dly == 0) pend = 1'b0;
            else pend_dly--;
        end
        if (e_gnt) begin
            grant_log.push_back(sel); grant_cyc.push_back(cyc);
            busy_owner = sel; wait_cnt = 0; locked = -1; waiting[sel] = 1'b1; last_gnt = sel;
            idx = int'(m_addr[sel][9:2]);
            exp_we[sel] = m_we[sel];
            if (m_we[sel]) ref_mem[idx] = merge(ref_mem[idx], m_wdata[sel], m_be[sel]);
            else exp_rd[sel] = ref_mem[idx];
            idx = int'(s_addr_o[9:2]);
            if (s_we_o) begin
                slave_mem[idx] = merge(slave_mem[idx], s_wdata_o, s_be_o);
                pend_data = $urandom;
            end else begin
                pend_data = slave_mem[idx];
            end
            pend = 1'b1;
            pend_dly = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 2));
        end else if (e_sreq) begin
            locked = sel;
        end
        if (!m_req[1]) starve = 0;
        else if (e_gnt && sel == 1) starve = 0;
        else if (e_gnt && sel == 0 && starve < LIMIT) starve++;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int t0;
        total = 0; passed = 0; cyc = 0;
        model_reset();
        want_pct[0] = 0; want_pct[1] = 0;
        ready_pct = 100; fixed_lat = -1; spurious = 1'b0; no_rsp = 1'b0;
        last_rdata[0] = '0; last_rdata[1] = '0; rv_cyc[0] = -1; rv_cyc[1] = -1;
        for (int i = 0; i < 256; i++) begin
            slave_mem[i] = $urandom; ref_mem[i] = slave_mem[i];
        end
        slave_mem[8'h40] = 32'hDEAD_BEEF; ref_mem[8'h40] = 32'hDEAD_BEEF;
        for (int x = 0; x < 2; x++) begin
            m_req[x] = 1'b0; m_addr[x] = '0; m_we[x] = 1'b0; m_be[x] = '0; m_wdata[x] = '0;
        end
        s_ready_i = 1'b1; s_rvalid_i = 1'b0; s_rdata_i = 32'h1234_5678;

        // Reset: outputs forced to 0 even with requests and slave handshakes present
        rst = 1'b1;
        #1 rst = 1'b0;
        issue(0, 32'h40, 1'b1, 4'hF, 32'h55);
        issue(1, 32'h80, 1'b0, 4'hF, 32'h0);
        #2 check_quiet("reset");
        m_req[0] = 1'b0; m_req[1] = 1'b0;
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;

        // T1: M1 read of 0x100, response two cycles after the grant
        fixed_lat = 1; grant_log.delete(); grant_cyc.delete();
        t0 = cyc;
        issue(1, 32'h100, 1'b0, 4'hF, 32'h0);
        run(4);
        check("t1_ngnt", grant_log.size(), 32'd1);
        if (grant_log.size() >= 1) begin
            check("t1_gnt_who", grant_log[0], 32'd1);
            check("t1_gnt_cyc", grant_cyc[0] - t0, 32'd0);
        end
        check("t1_rv_cyc", rv_cyc[1] - t0, 32'd2);
        check("t1_rdata", last_rdata[1], 32'hDEAD_BEEF);

        // T2: simultaneous M0 write and M1 read
        fixed_lat = 0; grant_log.delete(); grant_cyc.delete();
        issue(0, 32'h24, 1'b1, 4'b0101, 32'hA5A5_5A5A);
        issue(1, 32'h24, 1'b0, 4'hF, 32'h0);
        run(6);
        check("t2_ngnt", grant_log.size(), 32'd2);
        if (grant_log.size() >= 2) begin
            check("t2_first", grant_log[0], 32'd0);
            check("t2_second", grant_log[1], 32'd1);
            check("t2_gap", grant_cyc[1], rv_cyc[0] + 1);
        end

        // T3: both masters request continuously -> starvation relief every LIMIT grants
        grant_log.delete(); grant_cyc.delete();
        want_pct[0] = 100; want_pct[1] = 100;
        run(30);
        want_pct[0] = 0; want_pct[1] = 0;
        run(8);
        check("t3_ngnt", 32'(grant_log.size() >= 6), 32'd1);
        if (grant_log.size() >= 6)
            for (int i = 0; i < 6; i++) check("t3_order", grant_log[i], t3_exp[i]);

        // T4: M1 locked in the request phase while M0 arrives and the slave stalls
        grant_log.delete(); grant_cyc.delete();
        ready_pct = 0;
        issue(1, 32'h3C0, 1'b0, 4'hF, 32'h0);
        run(1);
        issue(0, 32'h010, 1'b0, 4'hF, 32'h0);
        run(2);
        ready_pct = 100;
        run(6);
        check("t4_ngnt", grant_log.size(), 32'd2);
        if (grant_log.size() >= 2) begin
            check("t4_first", grant_log[0], 32'd1);
            check("t4_second", grant_log[1], 32'd0);
        end

        // Stray slave response while idle is ignored
        spurious = 1'b1;
        run(2);
        spurious = 1'b0;

        // T5: reset during WAIT_RSP, late response after release
        fixed_lat = 3;
        issue(0, 32'h200, 1'b0, 4'hF, 32'h0);
        run(1);
        check("t5_in_wait", 32'(busy_owner), 32'd0);
        rst = 1'b0;
        m_req[0] = 1'b0;
        issue(1, 32'h300, 1'b0, 4'hF, 32'h0);
        #2 check_quiet("t5_rst");
        m_req[1] = 1'b0;
        model_reset();
        @(posedge clk); #1 rst = 1'b1;
        spurious = 1'b1;
        run(1);
        spurious = 1'b0;
        run(2);

`ifdef ARB_TIMEOUT_EN
        // T6: no response -> error on the TMO-th waiting cycle; then a response racing the expiry
        no_rsp = 1'b1;
        issue(0, 32'h44, 1'b0, 4'hF, 32'h0);
        t0 = cyc;
        run(TMO + 3);
        check("t6_err_cyc", rv_cyc[0] - t0, 32'(TMO));
        no_rsp = 1'b0;
        fixed_lat = TMO - 1;
        issue(1, 32'h48, 1'b0, 4'hF, 32'h0);
        t0 = cyc;
        run(TMO + 3);
        check("t6_race_cyc", rv_cyc[1] - t0, 32'(TMO));
        check("t6_race_data", last_rdata[1], ref_mem[8'h12]);
`endif

        // Randomized traffic
        fixed_lat = -1; ready_pct = 60;
        want_pct[0] = 70; want_pct[1] = 60;
        run(3000);
        want_pct[0] = 0; want_pct[1] = 0;
        run(12);
        check("drain_idle", 32'(busy_owner), 32'hFFFF_FFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
